// File: rtl/io_defs.sv
// Shared I/O-space definitions: register offsets, status bit positions, transmitter FSM encoding.
package io_defs;

    localparam logic OFF_STATUS = 1'b0;
    localparam logic OFF_TBR    = 1'b1;

    localparam int ST_FO  = 0;
    localparam int ST_TXB = 1;
    localparam int ST_OVR = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while run is high; tick is high for the last count.
// Held at zero while run is low, so each enable starts a full bit period.
module bit_timer #(
    parameter int BIT_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic clock,
    input  logic reset_,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!run || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx_interface.sv
// Port-mapped 8N1 serial transmitter: one-byte TBR, polled STATUS {OVR,TXB,FO}, registered txd.
// A captured byte starts its start bit one clock later when idle; writes to a full TBR are dropped and flag OVR.
module serial_tx_interface
    import io_defs::*;
#(
    parameter int BIT_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       s_,
    input  logic       a0,
    inout  wire  [7:0] d7_d0,
    input  logic       ior_,
    input  logic       iow_,
    output logic       txd
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       txd_q, txd_d;
    logic [7:0] tbr_q, tbr_d;
    logic       fo_q, fo_d;
    logic       ovr_q, ovr_d;
    logic       rd_q, rd_d;
    logic       iow_prev_q;
    logic       tick;
    logic       xfer;
    logic       wr_tbr;
    logic       status_rd;
    logic [7:0] status;
    logic [7:0] rd_dat;

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES),
        .CNT_W      (CNT_W)
    ) u_bit_timer (
        .clock  (clock),
        .reset_ (reset_),
        .run    (state_q != TX_IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= TX_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

    // A full TBR is moved into the shifter from IDLE, or at the end of STOP for gapless frames.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        xfer    = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (!fo_q) begin
                    xfer    = 1'b1;
                    shift_d = tbr_q;
                    bit_d   = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) state_d = TX_DATA;
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (!fo_q) begin
                        xfer    = 1'b1;
                        shift_d = tbr_q;
                        bit_d   = '0;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    assign txd = txd_q;

    assign wr_tbr    = !s_ && !iow_ && iow_prev_q && (a0 == OFF_TBR);
    assign status_rd = !s_ && !ior_ && (a0 == OFF_STATUS);

    // OVR clears on the first edge with ior_ high after a sampled STATUS read; a new overrun wins.
    always_comb begin
        tbr_d = tbr_q;
        fo_d  = fo_q | xfer;
        ovr_d = ovr_q;
        rd_d  = ior_ ? 1'b0 : (rd_q | status_rd);
        if (rd_q && ior_) begin
            ovr_d = 1'b0;
        end
        if (wr_tbr) begin
            if (fo_q || xfer) begin
                tbr_d = d7_d0;
                fo_d  = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            tbr_q      <= '0;
            fo_q       <= 1'b1;
            ovr_q      <= 1'b0;
            rd_q       <= 1'b0;
            iow_prev_q <= 1'b1;
        end else begin
            tbr_q      <= tbr_d;
            fo_q       <= fo_d;
            ovr_q      <= ovr_d;
            rd_q       <= rd_d;
            iow_prev_q <= iow_;
        end
    end

    always_comb begin
        status         = '0;
        status[ST_FO]  = fo_q;
        status[ST_TXB] = (state_q != TX_IDLE);
        status[ST_OVR] = ovr_q;
    end

    assign rd_dat = (a0 == OFF_STATUS) ? status : 8'h00;
    assign d7_d0  = (!s_ && !ior_) ? rd_dat : 8'hzz;

endmodule

// File: tb/tb_serial_tx_interface.sv
// Bench for serial_tx_interface with BIT_CYCLES=4: bus tasks drive the I/O port, a txd monitor checks frames against a queue.
module tb_serial_tx_interface;

    localparam int BC = 4;

    typedef struct {
        logic       a0w;
        logic [7:0] data;
        logic [9:0] frame;
        logic [7:0] st_busy;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_;
    logic       s_;
    logic       a0;
    logic       ior_;
    logic       iow_;
    wire  [7:0] d7_d0;
    logic       txd;
    logic [7:0] tb_dat;
    logic       tb_en;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [9:0] exp_q[$];
    int         start_cyc[$];

    assign d7_d0 = tb_en ? tb_dat : 8'hzz;

    serial_tx_interface #(
        .BIT_CYCLES (BC),
        .CNT_W      (16)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .s_     (s_),
        .a0     (a0),
        .d7_d0  (d7_d0),
        .ior_   (ior_),
        .iow_   (iow_),
        .txd    (txd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic off, input logic [7:0] d);
        @(negedge clock);
        s_ = 1'b0; a0 = off; tb_dat = d; tb_en = 1'b1; iow_ = 1'b0;
        @(negedge clock);
        iow_ = 1'b1; s_ = 1'b1; tb_en = 1'b0;
    endtask

    task automatic bus_read(input logic off, output logic [7:0] d);
        @(negedge clock);
        s_ = 1'b0; a0 = off; ior_ = 1'b0;
        #1 d = d7_d0;
        @(negedge clock);
        ior_ = 1'b1; s_ = 1'b1;
    endtask

    task automatic wait_status(input logic [7:0] target, input int budget, input string name);
        logic [7:0] r;
        bit hit;
        hit = 1'b0;
        r   = 8'hxx;
        for (int i = 0; i < budget && !hit; i++) begin
            bus_read(1'b0, r);
            if (r === target) hit = 1'b1;
        end
        check(name, {8'h00, r}, {8'h00, target});
    endtask

    // txd monitor: every start bit pops one expected frame and checks all 10*BC clocks of it.
    initial begin
        logic [9:0]  fr;
        logic [39:0] got;
        bit          mism, aborted, have;
        forever begin
            @(negedge clock);
            if (reset_ === 1'b1 && txd === 1'b0) begin
                start_cyc.push_back(cyc);
                have = (exp_q.size() > 0);
                fr   = 10'h3FF;
                if (have) fr = exp_q.pop_front();
                mism = 1'b0; aborted = 1'b0; got = '0;
                for (int k = 0; k < 10 * BC; k++) begin
                    if (k > 0) @(negedge clock);
                    if (reset_ !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    got[k] = txd;
                    if (txd !== fr[k / BC]) mism = 1'b1;
                end
                if (!aborted) begin
                    vectors++;
                    if (!have) begin
                        miscompares++;
                        $display("FAIL frame: unexpected frame %b, no byte queued", got);
                    end else if (mism) begin
                        miscompares++;
                        $display("FAIL frame: txd per clock %b, expected frame bits %b", got, fr);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        vec_t       tbl[5];
        int         n0;
        int         gap;
        bit         ok;

        tbl[0] = '{1'b1, 8'hA5, 10'b11_0100_1010,       8'h03};
        tbl[1] = '{1'b1, 8'h00, {1'b1, 8'h00, 1'b0},    8'h03};
        tbl[2] = '{1'b1, 8'hFF, {1'b1, 8'hFF, 1'b0},    8'h03};
        tbl[3] = '{1'b0, 8'h77, 10'h000,                8'h01};
        tbl[4] = '{1'b1, 8'h3C, {1'b1, 8'h3C, 1'b0},    8'h03};

        reset_ = 1'b0; s_ = 1'b1; a0 = 1'b0; ior_ = 1'b1; iow_ = 1'b1;
        tb_dat = 8'h00; tb_en = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_txd", {15'h0, txd}, 16'h0001);
        reset_ = 1'b1;

        bus_read(1'b0, r); check("reset_status", {8'h00, r}, 16'h0001);
        bus_read(1'b1, r); check("read_off1", {8'h00, r}, 16'h0000);

        @(negedge clock);
        s_ = 1'b1; ior_ = 1'b0; tb_dat = 8'h5A; tb_en = 1'b1;
        #1 check("bus_hiz_unselected", {8'h00, d7_d0}, 16'h005A);
        @(negedge clock);
        ior_ = 1'b1; tb_en = 1'b0;

        for (int i = 0; i < 5; i++) begin
            bus_write(tbl[i].a0w, tbl[i].data);
            if (tbl[i].a0w) exp_q.push_back(tbl[i].frame);
            repeat (2) @(negedge clock);
            bus_read(1'b0, r);
            check($sformatf("vec%0d_busy", i), {8'h00, r}, {8'h00, tbl[i].st_busy});
            wait_status(8'h01, 40, $sformatf("vec%0d_done", i));
        end

        // Back-to-back frames with no idle gap.
        n0 = start_cyc.size();
        bus_write(1'b1, 8'h0F); exp_q.push_back({1'b1, 8'h0F, 1'b0});
        wait_status(8'h03, 20, "b2b_fo");
        bus_write(1'b1, 8'hF0); exp_q.push_back({1'b1, 8'hF0, 1'b0});
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus_read(1'b0, r);
            if (r[1] !== 1'b1) ok = 1'b0;
        end
        check("b2b_txb_held", {15'h0, ok}, 16'h0001);
        wait_status(8'h01, 60, "b2b_done");
        gap = -1;
        if (start_cyc.size() >= n0 + 2) gap = start_cyc[n0 + 1] - start_cyc[n0];
        check("b2b_gap", gap[15:0], 16'(10 * BC));

        // Overrun: 0x33 arrives while 0x22 still waits in TBR.
        bus_write(1'b1, 8'h11); exp_q.push_back({1'b1, 8'h11, 1'b0});
        bus_write(1'b1, 8'h22); exp_q.push_back({1'b1, 8'h22, 1'b0});
        bus_write(1'b1, 8'h33);
        repeat (45) @(negedge clock);
        bus_read(1'b0, r); check("ovr_set", {8'h00, r}, 16'h0007);
        bus_read(1'b0, r); check("ovr_clear", {8'h00, r}, 16'h0003);
        wait_status(8'h01, 60, "ovr_done");

        // Long write strobe yields one frame.
        n0 = start_cyc.size();
        @(negedge clock);
        s_ = 1'b0; a0 = 1'b1; tb_dat = 8'h55; tb_en = 1'b1; iow_ = 1'b0;
        exp_q.push_back({1'b1, 8'h55, 1'b0});
        repeat (20) @(negedge clock);
        iow_ = 1'b1; s_ = 1'b1; tb_en = 1'b0;
        wait_status(8'h01, 80, "long_done");
        check("long_frames", 16'(start_cyc.size() - n0), 16'h0001);

        // Reset during data bit 3.
        n0 = start_cyc.size();
        bus_write(1'b1, 8'hC3); exp_q.push_back({1'b1, 8'hC3, 1'b0});
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clock);
            if (txd === 1'b0) ok = 1'b1;
        end
        check("rst_frame_started", {15'h0, ok}, 16'h0001);
        repeat (17) @(negedge clock);
        #1 reset_ = 1'b0;
        #1 check("rst_txd_async", {15'h0, txd}, 16'h0001);
        repeat (3) @(negedge clock);
        reset_ = 1'b1;
        bus_read(1'b0, r); check("rst_status", {8'h00, r}, 16'h0001);
        repeat (60) @(negedge clock);
        check("rst_no_residual", 16'(start_cyc.size() - n0), 16'h0001);

        check("queue_empty", 16'(exp_q.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
